// File: rtl/hld_multi.sv
// Harmonic lock detector: counts 0->1 tap transitions per reference edge and forces a relock
// when too many mismatches land in one window. Define HLD_EVCNT_EN to build the event counter.
module hld_multi #(
  parameter int unsigned NTAP     = 8,
  parameter int unsigned MW       = 3,
  parameter int unsigned WIN      = 16,
  parameter int unsigned ERR_TH   = 4,
  parameter int unsigned PD_LEN   = 4,
  parameter int unsigned HOLD_LEN = 32,
  parameter int unsigned LOCK_CNT = 8
) (
  input  logic                     clk_ext,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NTAP-1:0]          taps,
  input  logic [MW-1:0]            m_exp,
  output logic                     reset_pd,
  output logic                     locked,
  output logic [$clog2(NTAP)-1:0]  edge_cnt,
  output logic [1:0]               state,
  output logic [7:0]               hl_events
);

  localparam int unsigned CW   = $clog2(NTAP);
  localparam int unsigned CMPW = (CW > MW) ? CW : MW;
  localparam int unsigned WW   = (WIN > 1) ? $clog2(WIN) : 1;
  localparam int unsigned EW   = $clog2(ERR_TH + 1);
  localparam int unsigned GW   = $clog2(LOCK_CNT + 1);
  localparam int unsigned TMAX = (PD_LEN > HOLD_LEN) ? PD_LEN : HOLD_LEN;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [WW-1:0] WLAST = WW'(WIN - 1);
  localparam logic [EW-1:0] ELAST = EW'(ERR_TH - 1);
  localparam logic [GW-1:0] GMAX  = GW'(LOCK_CNT);
  localparam logic [GW-1:0] GPRE  = GW'(LOCK_CNT - 1);
  localparam logic [TW-1:0] PLAST = TW'(PD_LEN - 1);
  localparam logic [TW-1:0] HLAST = TW'(HOLD_LEN - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMonitor = 2'd1,
    StPulse   = 2'd2,
    StHold    = 2'd3
  } st_e;

  st_e             st_q;
  logic [NTAP-1:0] t1_q, t2_q;
  logic [2:0]      vpipe_q;
  logic [WW-1:0]   wcnt_q;
  logic [EW-1:0]   err_q;
  logic [GW-1:0]   good_run_q;
  logic [TW-1:0]   tcnt_q;
  logic [CW-1:0]   cnt_d;
  logic            valid, mism, enter_pulse;

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NTAP - 1; i++) begin
      if (!t2_q[i] && t2_q[i+1]) cnt_d = cnt_d + CW'(1);
    end
  end

  assign valid       = vpipe_q[2];
  assign mism        = (CMPW'(edge_cnt) != CMPW'(m_exp));
  assign enter_pulse = en && (st_q == StMonitor) && valid && mism && (err_q == ELAST);
  assign state       = st_q;

  // Synchroniser, transition counter and valid pipe run in every state.
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      t1_q     <= '0;
      t2_q     <= '0;
      edge_cnt <= '0;
      vpipe_q  <= '0;
    end else begin
      t1_q     <= taps;
      t2_q     <= t1_q;
      edge_cnt <= cnt_d;
      vpipe_q  <= en ? {vpipe_q[1:0], 1'b1} : 3'b000;
    end
  end

  always_ff @(posedge clk_ext) begin
    if (rst || !en) begin
      st_q       <= StIdle;
      reset_pd   <= 1'b0;
      locked     <= 1'b0;
      wcnt_q     <= '0;
      err_q      <= '0;
      good_run_q <= '0;
      tcnt_q     <= '0;
    end else begin
      unique case (st_q)
        StIdle: st_q <= StMonitor;
        StMonitor: begin
          if (enter_pulse) begin
            st_q       <= StPulse;
            reset_pd   <= 1'b1;
            locked     <= 1'b0;
            wcnt_q     <= '0;
            err_q      <= '0;
            good_run_q <= '0;
            tcnt_q     <= '0;
          end else begin
            if (valid && mism) begin
              good_run_q <= '0;
              locked     <= 1'b0;
            end else if (valid) begin
              if (good_run_q != GMAX) good_run_q <= good_run_q + GW'(1);
              locked <= (good_run_q == GMAX) || (good_run_q == GPRE);
            end
            // Window boundary clears err even if this cycle also mismatched.
            if (wcnt_q == WLAST) begin
              wcnt_q <= '0;
              err_q  <= '0;
            end else begin
              wcnt_q <= wcnt_q + WW'(1);
              if (valid && mism) err_q <= err_q + EW'(1);
            end
          end
        end
        StPulse: begin
          if (tcnt_q == PLAST) begin
            st_q     <= StHold;
            reset_pd <= 1'b0;
            tcnt_q   <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        StHold: begin
          if (tcnt_q == HLAST) begin
            st_q   <= StMonitor;
            tcnt_q <= '0;
            wcnt_q <= '0;
            err_q  <= '0;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
      endcase
    end
  end

`ifdef HLD_EVCNT_EN
  always_ff @(posedge clk_ext) begin
    if (rst) begin
      hl_events <= 8'd0;
    end else if (enter_pulse && (hl_events != 8'hFF)) begin
      hl_events <= hl_events + 8'd1;
    end
  end
`else
  assign hl_events = 8'd0;
`endif

endmodule

// File: tb/tb_hld_multi.sv
// Randomised and directed bench for hld_multi against a cycle-level behavioural model.
module tb_hld_multi;

  localparam int NTAP = 8, WIN = 16, ERR_TH = 4, PD_LEN = 4, HOLD_LEN = 32, LOCK_CNT = 8;

  logic       clk_ext = 1'b0;
  logic       rst = 1'b1, en = 1'b0;
  logic [7:0] taps = 8'h00;
  logic [2:0] m_exp = 3'd0;
  logic       reset_pd, locked;
  logic [2:0] edge_cnt;
  logic [1:0] state;
  logic [7:0] hl_events;

  hld_multi dut (
    .clk_ext  (clk_ext),
    .rst      (rst),
    .en       (en),
    .taps     (taps),
    .m_exp    (m_exp),
    .reset_pd (reset_pd),
    .locked   (locked),
    .edge_cnt (edge_cnt),
    .state    (state),
    .hl_events(hl_events)
  );

  always #5 clk_ext = ~clk_ext;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cnt01(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < NTAP - 1; i++) if (!v[i] && v[i+1]) c++;
    return c;
  endfunction

  // Reference model: hist[k] is the tap sample taken k edges ago (0 = this edge).
  logic [7:0] hist[$];
  int m_mode = 0, m_wc = 0, m_er = 0, m_gr = 0, m_pc = 0, m_ev = 0, en_run = 0;
  bit m_rp = 0, m_lk = 0;

  task automatic model_edge();
    int  dc;
    bit  valid, mm;
    dc    = cnt01(hist[2]);
    valid = (en_run >= 3);
    mm    = (dc != int'(m_exp));
    if (rst) begin
      m_mode = 0; m_wc = 0; m_er = 0; m_gr = 0; m_pc = 0; m_ev = 0; en_run = 0;
      m_rp = 0; m_lk = 0;
      hist.delete();
      repeat (3) hist.push_back(8'h00);
    end else begin
      if (!en) begin
        m_mode = 0; m_wc = 0; m_er = 0; m_gr = 0; m_pc = 0; m_rp = 0; m_lk = 0;
        en_run = 0;
      end else begin
        case (m_mode)
          0: m_mode = 1;
          1: begin
            if (valid && mm && (m_er + 1 == ERR_TH)) begin
              m_mode = 2; m_rp = 1; m_pc = 0; m_wc = 0; m_er = 0; m_gr = 0; m_lk = 0;
              if (m_ev < 255) m_ev++;
            end else begin
              if (valid && mm) begin
                m_er++;
                m_gr = 0;
              end else if (valid && m_gr < LOCK_CNT) begin
                m_gr++;
              end
              if (m_wc == WIN - 1) begin
                m_wc = 0;
                m_er = 0;
              end else begin
                m_wc++;
              end
              m_lk = (m_gr == LOCK_CNT);
            end
          end
          2: begin
            if (m_pc == PD_LEN - 1) begin
              m_mode = 3; m_rp = 0; m_pc = 0;
            end else m_pc++;
          end
          default: begin
            if (m_pc == HOLD_LEN - 1) begin
              m_mode = 1; m_pc = 0; m_wc = 0; m_er = 0;
            end else m_pc++;
          end
        endcase
        en_run++;
      end
      hist.push_front(taps);
      void'(hist.pop_back());
    end
  endtask

  task automatic step();
    int exp_ev;
    @(posedge clk_ext);
    model_edge();
    #1;
`ifdef HLD_EVCNT_EN
    exp_ev = m_ev;
`else
    exp_ev = 0;
`endif
    chk("reset_pd", int'(reset_pd), int'(m_rp));
    chk("locked", int'(locked), int'(m_lk));
    chk("edge_cnt", int'(edge_cnt), cnt01(hist[2]));
    chk("state", int'(state), m_mode);
    chk("hl_events", int'(hl_events), exp_ev);
  endtask

  logic [7:0] pat[5];
  int         st_tr[100];

  initial begin
    int lock_at, unlock_at, pd_seen, plen, hlen, idx, rises, pulse_at, exp_ev3;
    bit prev_pd;
    pat[0] = 8'h00; pat[1] = 8'hF0; pat[2] = 8'hCC; pat[3] = 8'hA8; pat[4] = 8'hAA;
    repeat (3) hist.push_back(8'h00);

    // Reset then lock on a single-transition pattern
    rst = 1'b1; en = 1'b0;
    step(); step();
    rst = 1'b0; en = 1'b1; m_exp = 3'd1; taps = 8'hF0;
    lock_at = -1; pd_seen = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (locked && lock_at < 0) lock_at = n;
      if (reset_pd) pd_seen++;
    end
    chk("lock_latency", lock_at, 3 + LOCK_CNT);
    chk("lock_no_pd", pd_seen, 0);
    chk("lock_edge_cnt", int'(edge_cnt), 1);

    // Harmonic lock: two transitions against M=1
    taps = 8'hCC; unlock_at = -1;
    for (int n = 1; n <= 100; n++) begin
      step();
      st_tr[n-1] = int'(state);
      if (!locked && unlock_at < 0) unlock_at = n;
    end
    chk("unlock_latency", unlock_at, 4);
    idx = 0;
    while (idx < 100 && st_tr[idx] != 2) idx++;
    plen = 0;
    while (idx < 100 && st_tr[idx] == 2) begin plen++; idx++; end
    hlen = 0;
    while (idx < 100 && st_tr[idx] == 3) begin hlen++; idx++; end
    chk("pulse_len", plen, PD_LEN);
    chk("hold_len", hlen, HOLD_LEN);
    chk("after_hold", (idx < 100) ? st_tr[idx] : -1, 1);

    // Window filtering: exactly 3 mismatches in every 16 consecutive decisions
    en = 1'b0; taps = 8'hF0; step();
    en = 1'b1;
    repeat (20) step();
    pd_seen = 0;
    for (int k = 0; k < 4 * WIN; k++) begin
      taps = (k % 16 == 2 || k % 16 == 7 || k % 16 == 12) ? 8'hCC : 8'hF0;
      step();
      if (reset_pd) pd_seen++;
    end
    chk("win_no_pd", pd_seen, 0);
    taps = 8'hCC;
    repeat (4) step();
    taps = 8'hF0; pd_seen = 0;
    repeat (6) begin step(); if (reset_pd) pd_seen++; end
    chk("win_4th_pd", (pd_seen > 0) ? 1 : 0, 1);

    // Boundary: mismatches decided at wcnt 12..15
    en = 1'b0; taps = 8'hF0; step();
    en = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      taps = (n >= 11 && n <= 14) ? 8'hCC : 8'hF0;
      step();
    end
    chk("boundary_pulse", int'(state), 2);

    // Abort during pulse cycle 2, then re-enable with a mismatching history
    step();
    en = 1'b0; taps = 8'hCC;
    step();
    chk("abort_pd", int'(reset_pd), 0);
    chk("abort_state", int'(state), 0);
    step();
    en = 1'b1; pulse_at = -1;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (state == 2'd2 && pulse_at < 0) pulse_at = n;
    end
    chk("reenable_pulse_at", pulse_at, 7);

    // Event counter: three harmonic events, survives en toggling
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b1; taps = 8'hCC; m_exp = 3'd1; rises = 0; prev_pd = 1'b0;
    for (int n = 0; n < 300 && rises < 3; n++) begin
      step();
      if (reset_pd && !prev_pd) rises++;
      prev_pd = reset_pd;
    end
    chk("ev_rises", rises, 3);
    taps = 8'hF0;
    en = 1'b0; repeat (2) step();
    en = 1'b1; repeat (5) step();
`ifdef HLD_EVCNT_EN
    exp_ev3 = 3;
`else
    exp_ev3 = 0;
`endif
    chk("ev_kept", int'(hl_events), exp_ev3);

    // Random phase
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 7) == 0)
        taps = ($urandom_range(0, 9) < 7) ? pat[$urandom_range(0, 4)] : 8'($urandom);
      if ($urandom_range(0, 31) == 0) m_exp = 3'($urandom_range(0, 4));
      en  = ($urandom_range(0, 63) != 0);
      rst = ($urandom_range(0, 255) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
